// File: rtl/vga_frame_monitor.sv
// -----------------------------------------------------------------------------
// vga_frame_monitor
//
// Watches the hsync/vsync/RGB stream that drives the VGA connector, measures
// line and frame timing, compares it with the 640x480 timing parameters and
// produces a 16-bit signature of the active pixels of every frame.
//
// Sampling: dclk_en is a one-clk qualifier with no back-pressure. Every clk
// edge with dclk_en=1 is exactly one pixel sample; on all other edges every
// register holds its value (frame_done is the only exception and drops to 0).
//
// Ports:
//   clk        in   system clock
//   clr        in   synchronous reset, active-low
//   dclk_en    in   pixel-sample strobe
//   hsync      in   horizontal sync, active-low
//   vsync      in   vertical sync, active-low
//   red        in   3-bit pixel red
//   green      in   3-bit pixel green
//   blue       in   3-bit pixel blue
//   line_len   out  sample count of the last completed line
//   hs_width   out  last measured hsync low width, in samples
//   frame_len  out  line count of the last completed frame
//   vs_width   out  last measured vsync low width, in lines
//   frame_sum  out  active-pixel signature of the last completed frame
//   frame_done out  one-clk pulse when a frame result is published
//   frame_ok   out  verdict for the last published frame
//   locked     out  stream has matched the parameters for 2+ frames
//   err_cnt    out  bad-frame count, saturating at 255
// -----------------------------------------------------------------------------
module vga_frame_monitor #(
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int ACT_H_START = 144,
    parameter int ACT_H_END   = 784,
    parameter int V_TOTAL     = 521,
    parameter int V_SYNC      = 2,
    parameter int ACT_V_START = 31,
    parameter int ACT_V_END   = 511
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        dclk_en,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [2:0]  red,
    input  logic [2:0]  green,
    input  logic [2:0]  blue,
    output logic [11:0] line_len,
    output logic [11:0] hs_width,
    output logic [11:0] frame_len,
    output logic [11:0] vs_width,
    output logic [15:0] frame_sum,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        locked,
    output logic [7:0]  err_cnt
);

    // FSM encoding
    localparam logic [1:0] SEARCH  = 2'd0;
    localparam logic [1:0] ACQUIRE = 2'd1;
    localparam logic [1:0] CHECK   = 2'd2;

    localparam logic [11:0] CNT_MAX     = 12'hFFF;
    localparam logic [11:0] H_TOTAL_C   = 12'(H_TOTAL);
    localparam logic [11:0] H_SYNC_C    = 12'(H_SYNC);
    localparam logic [11:0] H_ACT_LO    = 12'(ACT_H_START);
    localparam logic [11:0] H_ACT_HI    = 12'(ACT_H_END);
    localparam logic [11:0] V_TOTAL_C   = 12'(V_TOTAL);
    localparam logic [11:0] V_SYNC_C    = 12'(V_SYNC);
    localparam logic [11:0] V_ACT_LO    = 12'(ACT_V_START);
    localparam logic [11:0] V_ACT_HI    = 12'(ACT_V_END);
    localparam logic [18:0] PIX_EXPECT  =
        19'((ACT_H_END - ACT_H_START) * (ACT_V_END - ACT_V_START));
    localparam logic [18:0] PIX_MAX     = 19'h7FFFF;

    logic [1:0]  state;
    logic        hs_prev;
    logic        vs_prev;
    logic [11:0] h;
    logic [11:0] v;
    logic [15:0] csum;
    logic [18:0] pix_cnt;
    logic        line_err;
    logic        ok_seen;      // previous published frame was good

    logic        hs_fall;
    logic        hs_rise;
    logic        vs_fall;
    logic        vs_rise;
    logic [11:0] h_inc;
    logic [11:0] v_inc;
    logic [11:0] h_next;
    logic [11:0] v_next;
    logic        active;
    logic        line_chk_err;
    logic        frame_good;
    logic        publish;
    logic [15:0] csum_next;

    assign hs_fall = hs_prev & ~hsync;
    assign hs_rise = ~hs_prev & hsync;
    assign vs_fall = vs_prev & ~vsync;
    assign vs_rise = ~vs_prev & vsync;

    // Saturating increments: a lost sync parks the counter at 4095, so the
    // next measurement reads 4095 and can never match a sane parameter.
    assign h_inc = (h == CNT_MAX) ? CNT_MAX : h + 12'd1;
    assign v_inc = (v == CNT_MAX) ? CNT_MAX : v + 12'd1;

    // Index of the current sample; vsync fall outranks hsync fall for v.
    assign h_next = hs_fall ? 12'd0 : h_inc;
    assign v_next = vs_fall ? 12'd0 : (hs_fall ? v_inc : v);

    assign active = (h_next >= H_ACT_LO) && (h_next < H_ACT_HI) &&
                    (v_next >= V_ACT_LO) && (v_next < V_ACT_HI);

    assign line_chk_err = (state != SEARCH) &&
                          ((hs_fall && (h_inc != H_TOTAL_C)) ||
                           (hs_rise && (h_next != H_SYNC_C)));

    // vs_width still holds the value measured during the frame now ending;
    // line_err is combined with any check made in this same sample.
    assign frame_good = !(line_err || line_chk_err) &&
                        (v_inc == V_TOTAL_C) &&
                        (vs_width == V_SYNC_C) &&
                        (pix_cnt == PIX_EXPECT);

    assign publish   = vs_fall && (state != SEARCH);
    assign csum_next = {csum[14:0], csum[15]} ^ {7'b0, red, green, blue};

    always_ff @(posedge clk) begin
        if (!clr) begin
            state      <= SEARCH;
            hs_prev    <= 1'b1;
            vs_prev    <= 1'b1;
            h          <= 12'd0;
            v          <= 12'd0;
            csum       <= 16'd0;
            pix_cnt    <= 19'd0;
            line_err   <= 1'b0;
            ok_seen    <= 1'b0;
            line_len   <= 12'd0;
            hs_width   <= 12'd0;
            frame_len  <= 12'd0;
            vs_width   <= 12'd0;
            frame_sum  <= 16'd0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            locked     <= 1'b0;
            err_cnt    <= 8'd0;
        end else begin
            frame_done <= 1'b0;
            if (dclk_en) begin
                hs_prev <= hsync;
                vs_prev <= vsync;
                h       <= h_next;
                v       <= v_next;

                if (hs_fall) line_len <= h_inc;
                if (hs_rise) hs_width <= h_next;
                if (vs_rise) vs_width <= v_next;

                if (vs_fall) begin
                    frame_len <= v_inc;
                    frame_sum <= csum;
                    csum      <= 16'd0;
                    pix_cnt   <= 19'd0;
                    line_err  <= 1'b0;
                end else begin
                    if (active) begin
                        csum <= csum_next;
                        if (pix_cnt != PIX_MAX) pix_cnt <= pix_cnt + 19'd1;
                    end
                    if (line_chk_err) line_err <= 1'b1;
                end

                if (vs_fall) begin
                    state <= (state == SEARCH) ? ACQUIRE : CHECK;
                end

                if (publish) begin
                    frame_done <= 1'b1;
                    frame_ok   <= frame_good;
                    if (frame_good) begin
                        ok_seen <= 1'b1;
                        if (ok_seen) locked <= 1'b1;
                    end else begin
                        ok_seen <= 1'b0;
                        locked  <= 1'b0;
                        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// -----------------------------------------------------------------------------
// tb_vga_frame_monitor
//
// Drives whole frames described by a small record (line count, one odd line
// length, sync widths, pixel pattern, strobe spacing). The DUT is built with a
// scaled-down raster so that many frames fit in a short run. Expected frame
// results come either from a hand-written table or from a reference model
// that derives them from the frame description itself.
// -----------------------------------------------------------------------------
module tb_vga_frame_monitor;

    localparam int H_TOTAL     = 20;
    localparam int H_SYNC      = 3;
    localparam int ACT_H_START = 5;
    localparam int ACT_H_END   = 17;
    localparam int V_TOTAL     = 12;
    localparam int V_SYNC      = 2;
    localparam int ACT_V_START = 3;
    localparam int ACT_V_END   = 10;
    localparam int PIX_EXP     = (ACT_H_END - ACT_H_START) * (ACT_V_END - ACT_V_START);
    localparam int RES_W       = 74;
    localparam int N_ROWS      = 11;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        dclk_en = 1'b0;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic [2:0]  red = 3'd0;
    logic [2:0]  green = 3'd0;
    logic [2:0]  blue = 3'd0;
    logic [11:0] line_len;
    logic [11:0] hs_width;
    logic [11:0] frame_len;
    logic [11:0] vs_width;
    logic [15:0] frame_sum;
    logic        frame_done;
    logic        frame_ok;
    logic        locked;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    vga_frame_monitor #(
        .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC),
        .ACT_H_START(ACT_H_START), .ACT_H_END(ACT_H_END),
        .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC),
        .ACT_V_START(ACT_V_START), .ACT_V_END(ACT_V_END)
    ) dut (
        .clk(clk), .clr(clr), .dclk_en(dclk_en),
        .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .line_len(line_len), .hs_width(hs_width),
        .frame_len(frame_len), .vs_width(vs_width),
        .frame_sum(frame_sum), .frame_done(frame_done),
        .frame_ok(frame_ok), .locked(locked), .err_cnt(err_cnt)
    );

    // ---------------- records ----------------
    typedef struct packed {
        logic        ok;
        logic [11:0] line_len;
        logic [11:0] hs_width;
        logic [11:0] frame_len;
        logic [11:0] vs_width;
        logic [15:0] sum;
        logic        locked;
        logic [7:0]  err;
    } res_t;

    typedef struct {
        int   nlines;
        int   short_line;   // -1: every line is H_TOTAL long
        int   short_len;
        int   hsw;
        int   vsw;
        int   pix_mode;     // 0 zero, 1 single 9'h155 at last active pixel, 2 random
        bit   pause;
        int   gap;          // clk per sample, 0 = random 1..4
        res_t exp;
    } row_t;

    // ---------------- scoreboard ----------------
    logic [RES_W-1:0] exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_done = 0;
    int   n_pushed = 0;

    // model state
    int   falls = 0;
    int   ok_run = 0;
    int   m_err = 0;
    bit   have_pend = 0;
    bit   pend_hand = 0;
    res_t pend;
    res_t mon_r;
    row_t tbl[N_ROWS];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic res_t mk_res(bit ok, int ll, int hw, int fl, int vw, int sum, bit lk, int err);
        res_t r;
        r.ok = ok; r.line_len = 12'(ll); r.hs_width = 12'(hw); r.frame_len = 12'(fl);
        r.vs_width = 12'(vw); r.sum = 16'(sum); r.locked = lk; r.err = 8'(err);
        return r;
    endfunction

    function automatic row_t mk_row(int nl, int sl, int slen, int hsw, int vsw, int mode,
                                    bit pause, int gap, res_t e);
        row_t d;
        d.nlines = nl; d.short_line = sl; d.short_len = slen; d.hsw = hsw; d.vsw = vsw;
        d.pix_mode = mode; d.pause = pause; d.gap = gap; d.exp = e;
        return d;
    endfunction

    function automatic row_t rand_row(bit nominal);
        row_t d;
        int   r;
        d = mk_row(V_TOTAL, -1, H_TOTAL, H_SYNC, V_SYNC, 2, 0, 0, mk_res(0, 0, 0, 0, 0, 0, 0, 0));
        if (!nominal) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) d.nlines = V_TOTAL - 1;
            else if (r == 1) d.nlines = V_TOTAL + 1;
            if ($urandom_range(0, 3) == 0) begin
                d.short_line = int'($urandom_range(0, d.nlines - 1));
                d.short_len  = int'($urandom_range(18, 22));
            end
            if ($urandom_range(0, 5) == 0) d.hsw = int'($urandom_range(2, 4));
            if ($urandom_range(0, 5) == 0) d.vsw = int'($urandom_range(1, 3));
        end
        return d;
    endfunction

    // Called at the vsync fall that starts a frame: the frame before it is
    // published unless this is the first vsync fall since reset.
    task automatic publish_pending();
        res_t r;
        if (falls >= 1 && have_pend) begin
            r = pend;
            if (r.ok) ok_run++;
            else begin
                ok_run = 0;
                m_err  = (m_err < 255) ? m_err + 1 : 255;
            end
            if (!pend_hand) begin
                r.locked = (ok_run >= 2);
                r.err    = 8'(m_err);
            end
            exp_q.push_back(r);
            n_pushed++;
        end
        falls++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_sample(input logic hs, input logic vs, input logic [8:0] pix, input int gap);
        dclk_en = 1'b1;
        hsync   = hs;
        vsync   = vs;
        {red, green, blue} = pix;
        @(posedge clk); #1;
        dclk_en = 1'b0;
        for (int i = 1; i < gap; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_outputs(input string tag, input int ll, input int hw, input int fl,
                                 input int vw, input int sum, input bit ok, input bit lk,
                                 input int err);
        chk({tag, ".line_len"},   32'(line_len),   32'(ll));
        chk({tag, ".hs_width"},   32'(hs_width),   32'(hw));
        chk({tag, ".frame_len"},  32'(frame_len),  32'(fl));
        chk({tag, ".vs_width"},   32'(vs_width),   32'(vw));
        chk({tag, ".frame_sum"},  32'(frame_sum),  32'(sum));
        chk({tag, ".frame_ok"},   32'(frame_ok),   32'(ok));
        chk({tag, ".locked"},     32'(locked),     32'(lk));
        chk({tag, ".err_cnt"},    32'(err_cnt),    32'(err));
        chk({tag, ".frame_done"}, 32'(frame_done), 32'd0);
    endtask

    // Strobe idle for 1000 clk in the middle of table row 3: the outputs must
    // keep showing row 2's published result and the running line values.
    task automatic do_pause();
        check_outputs("pause_start", 20, 3, 12, 2, 0, 0, 0, 1);
        repeat (1000) @(posedge clk);
        #1;
        check_outputs("pause_end", 20, 3, 12, 2, 0, 0, 0, 1);
    endtask

    task automatic do_reset(input string tag);
        dclk_en = 1'b0;
        clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs(tag, 0, 0, 0, 0, 0, 0, 0, 0);
        clr = 1'b1;
        falls = 0; ok_run = 0; m_err = 0; have_pend = 0;
    endtask

    task automatic gen_frame(input row_t d, input bit use_hand, input int reset_line);
        logic [15:0] sum;
        logic [8:0]  pix;
        int          cnt;
        int          len;
        int          last_len;
        int          g;
        bit          lines_ok;
        bit          act;
        sum = 16'd0; cnt = 0; lines_ok = 1; last_len = H_TOTAL;
        publish_pending();
        for (int l = 0; l < d.nlines; l++) begin
            len = (l == d.short_line) ? d.short_len : H_TOTAL;
            if (len != H_TOTAL) lines_ok = 0;
            for (int c = 0; c < len; c++) begin
                if (d.pause && l == 6 && c == 10) do_pause();
                if (reset_line == l && c == 7) do_reset("reset_mid");
                act = (c >= ACT_H_START) && (c < ACT_H_END) &&
                      (l >= ACT_V_START) && (l < ACT_V_END);
                if (act) begin
                    case (d.pix_mode)
                        0:       pix = 9'h000;
                        1:       pix = (c == ACT_H_END - 1 && l == ACT_V_END - 1) ? 9'h155 : 9'h000;
                        default: pix = 9'($urandom_range(0, 511));
                    endcase
                    sum = {sum[14:0], sum[15]} ^ {7'b0, pix};
                    cnt++;
                end else begin
                    pix = 9'($urandom_range(0, 511));
                end
                g = (d.gap == 0) ? int'($urandom_range(1, 4)) : d.gap;
                send_sample(c >= d.hsw, l >= d.vsw, pix, g);
            end
            last_len = len;
        end
        if (d.hsw != H_SYNC) lines_ok = 0;
        if (use_hand) pend = d.exp;
        else begin
            pend.ok        = lines_ok && (d.nlines == V_TOTAL) && (d.vsw == V_SYNC) && (cnt == PIX_EXP);
            pend.line_len  = 12'((last_len > 4095) ? 4095 : last_len);
            pend.hs_width  = 12'(d.hsw);
            pend.frame_len = 12'(d.nlines);
            pend.vs_width  = 12'(d.vsw);
            pend.sum       = sum;
            pend.locked    = 1'b0;
            pend.err       = 8'd0;
        end
        have_pend = 1;
        pend_hand = use_hand;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (clr && frame_done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL frame_done: pulse with no frame result expected at %0t", $time);
            end else begin
                mon_r = exp_q.pop_front();
                chk("pub.frame_ok",  32'(frame_ok),  32'(mon_r.ok));
                chk("pub.line_len",  32'(line_len),  32'(mon_r.line_len));
                chk("pub.hs_width",  32'(hs_width),  32'(mon_r.hs_width));
                chk("pub.frame_len", 32'(frame_len), 32'(mon_r.frame_len));
                chk("pub.vs_width",  32'(vs_width),  32'(mon_r.vs_width));
                chk("pub.frame_sum", 32'(frame_sum), 32'(mon_r.sum));
                chk("pub.locked",    32'(locked),    32'(mon_r.locked));
                chk("pub.err_cnt",   32'(err_cnt),   32'(mon_r.err));
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        //                nl  sl  slen hsw vsw mode pause gap  ok  ll   hw fl  vw  sum    lk err
        tbl[0]  = mk_row(12, -1, 0,    3,  2,  0,   0,    4, mk_res(1, 20,   3, 12, 2, 0,     0, 0));
        tbl[1]  = mk_row(12, -1, 0,    3,  2,  1,   0,    4, mk_res(1, 20,   3, 12, 2, 'h155, 1, 0));
        tbl[2]  = mk_row(12,  5, 19,   3,  2,  0,   0,    4, mk_res(0, 20,   3, 12, 2, 0,     0, 1));
        tbl[3]  = mk_row(12, -1, 0,    3,  2,  0,   1,    0, mk_res(1, 20,   3, 12, 2, 0,     0, 1));
        tbl[4]  = mk_row(12, -1, 0,    3,  2,  0,   0,    0, mk_res(1, 20,   3, 12, 2, 0,     1, 1));
        tbl[5]  = mk_row(12, -1, 0,    3,  3,  0,   0,    0, mk_res(0, 20,   3, 12, 3, 0,     0, 2));
        tbl[6]  = mk_row(13, -1, 0,    3,  2,  0,   0,    0, mk_res(0, 20,   3, 13, 2, 0,     0, 3));
        tbl[7]  = mk_row(12, -1, 0,    4,  2,  0,   0,    0, mk_res(0, 20,   4, 12, 2, 0,     0, 4));
        tbl[8]  = mk_row(12, -1, 0,    3,  2,  0,   0,    0, mk_res(1, 20,   3, 12, 2, 0,     0, 4));
        tbl[9]  = mk_row(12, -1, 0,    3,  2,  1,   0,    0, mk_res(1, 20,   3, 12, 2, 'h155, 1, 4));
        tbl[10] = mk_row(12, 11, 5003, 3,  2,  0,   0,    1, mk_res(0, 4095, 3, 12, 2, 0,     0, 5));

        clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        clr = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < N_ROWS; i++) gen_frame(tbl[i], 1, -1);
        for (int i = 0; i < 10; i++) gen_frame(rand_row(0), 0, -1);

        // reset in the middle of a frame, then two frames before a publish
        gen_frame(rand_row(1), 0, 5);
        gen_frame(rand_row(1), 0, -1);
        gen_frame(rand_row(1), 0, -1);
        gen_frame(rand_row(0), 0, -1);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("frame_done_count", 32'(n_done), 32'(n_pushed));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_frame_monitor.md
Name: vga_frame_monitor

Overview:
Synthesizable checker that sits directly downstream of the VGA output stage of the NERP demo top. It consumes the hsync, vsync and 3-bit red/green/blue signals that drive the connector. It measures line and frame timing, checks it against the 640x480 timing parameters, and produces a per-frame pixel signature. It lets the on-board design and the bench check the video stream without dumping every cycle to a file.

Parameters:
H_TOTAL, 800, expected pixel samples per line
H_SYNC, 96, expected hsync low width in samples
ACT_H_START, 144, first active column index, counted from the hsync falling edge
ACT_H_END, 784, first column index after the active columns (exclusive)
V_TOTAL, 521, expected lines per frame
V_SYNC, 2, expected vsync low width in lines
ACT_V_START, 31, first active line index, counted from the vsync falling edge
ACT_V_END, 511, first line index after the active lines (exclusive)

Ports:
clk  in  1  system clock, 100 MHz
clr  in  1  synchronous reset, active-low
dclk_en  in  1  pixel-sample strobe; one clk wide, once per pixel (every 4 clk for 25 MHz)
hsync  in  1  horizontal sync, active-low
vsync  in  1  vertical sync, active-low
red  in  3  pixel red
green  in  3  pixel green
blue  in  3  pixel blue
line_len  out  12  sample count of the last completed line
hs_width  out  12  last measured hsync low width, in samples
frame_len  out  12  line count of the last completed frame
vs_width  out  12  last measured vsync low width, in lines
frame_sum  out  16  signature of the active pixels of the last completed frame
frame_done  out  1  one-clk pulse when a frame result is published
frame_ok  out  1  verdict for the last published frame
locked  out  1  stream matches the parameters
err_cnt  out  8  bad-frame count, saturating at 255

Behaviour:
- Reset and sampling
  - clr is synchronous active-low. While clr=0, every output and internal register is 0 and the FSM is SEARCH.
  - Signals are sampled only on clk edges where dclk_en=1; other cycles hold all state.
  - frame_done is high for exactly one clk: the cycle after the sample that published a result.
- Edge detection
  - The previous sampled hsync/vsync are registered with reset value 1.
  - A fall is prev=1,cur=0; a rise is prev=0,cur=1.
- Horizontal counter h (12 bit, saturates at 4095)
  - On an hsync fall: line_len <= h+1, then h <= 0.
  - Otherwise h <= h+1.
  - On an hsync rise: hs_width <= the index of that sample (the new h).
- Vertical counter v (12 bit, saturates at 4095)
  - On a vsync fall: frame_len <= v+1, then v <= 0. This takes priority over the hsync fall in the same sample.
  - Otherwise, on an hsync fall: v <= v+1.
  - On a vsync rise: vs_width <= the post-update v of that sample.
- Active region: the current sample's indices (h,v) satisfy ACT_H_START<=h<ACT_H_END and ACT_V_START<=v<ACT_V_END.
- Signature (16 bit)
  - For each active sample: csum <= rotl1(csum) XOR {7'b0, red, green, blue}.
  - The active-pixel counter (19 bit) increments on the same samples.
  - On a vsync fall: frame_sum <= csum, then csum and the pixel counter clear.
- Per-line check
  - Sticky line_err is set on any hsync fall, outside SEARCH, where line_len != H_TOTAL.
  - It is also set on any hsync rise, outside SEARCH, where the measured width != H_SYNC.
  - line_err clears on each vsync fall, after evaluation. The evaluation includes a check made in the same sample.
- FSM
  - SEARCH: on a vsync fall, go to ACQUIRE. No publish.
  - ACQUIRE or CHECK: on a vsync fall, publish (frame_done). frame_ok = !line_err && frame_len==V_TOTAL && vs_width==V_SYNC && pixcount==(ACT_H_END-ACT_H_START)*(ACT_V_END-ACT_V_START). Then go to CHECK.
  - vs_width in this check is the value from the frame just ended.
- locked and err_cnt
  - locked asserts after 2 consecutive ok frames.
  - Any bad frame clears locked and increments err_cnt.
- Saturation: if a counter stays at 4095 (sync lost), the next measured value is 4096 clipped to 4095, and that frame is bad.

Test Plan:
- Nominal 800x521 stream, dclk_en every 4 clk, all RGB 0 -> at the 2nd vsync fall: frame_done, line_len=800, hs_width=96, frame_len=521, vs_width=2, frame_sum=16'h0000, frame_ok=1. locked=1 after the 3rd vsync fall.
- RGB zero except (h=783,v=510)=9'h155 -> frame_sum=16'h0155, frame_ok=1.
- One line shortened to 799 samples -> that frame's frame_ok=0, err_cnt=1, locked=0. Re-locks after 2 good frames.
- dclk_en held low for 1000 clk mid-line -> no output changes; the next frame result is identical to nominal.
- clr=0 for 3 clk mid-frame -> all outputs 0. No frame_done until the 2nd vsync fall after release.
- hsync held high for 5000 samples -> line_len=4095, frame_ok=0, err_cnt increments.
